// File: rtl/goc_tx_sched.sv
// Round-robin frame scheduler sharing one GOC PWM transmitter between two frame
// sources, with a programmable inter-frame gap and a per-port frame-done pulse.
module goc_tx_sched #(
  parameter int GAP_W = 22
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             tx_enable,
  input  logic [GAP_W-1:0] gap_cycles,
  input  logic             rq0_req,
  input  logic             rq0_frame_valid,
  input  logic [7:0]       rq0_data,
  output logic             rq0_next,
  input  logic             rq1_req,
  input  logic             rq1_frame_valid,
  input  logic [7:0]       rq1_data,
  output logic             rq1_next,
  output logic [7:0]       tx_data,
  output logic             tx_empty,
  input  logic             tx_re,
  output logic             tx_start,
  output logic [1:0]       grant,
  output logic [1:0]       done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic             last_grant;
  logic             sel;
  logic             owner_req;
  logic             owner_valid;

  // On a tie the port that did not own the transmitter last time wins.
  assign sel = (rq0_req & rq1_req) ? ~last_grant : rq1_req;

  assign owner_req   = (grant[0] & rq0_req) | (grant[1] & rq1_req);
  assign owner_valid = (grant[0] & rq0_frame_valid) | (grant[1] & rq1_frame_valid);

  // grant is non-zero only in BUSY, so the datapath falls back to idle values elsewhere.
  assign tx_data  = ({8{grant[0]}} & rq0_data) | ({8{grant[1]}} & rq1_data);
  assign tx_empty = ~owner_valid;
  assign rq0_next = tx_re & grant[0] & rq0_frame_valid;
  assign rq1_next = tx_re & grant[1] & rq1_frame_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      grant      <= 2'b00;
      done       <= 2'b00;
      tx_start   <= 1'b0;
      busy       <= 1'b0;
      gap_cnt    <= '0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (tx_enable && (rq0_req || rq1_req)) begin
            state      <= BUSY;
            grant      <= sel ? 2'b10 : 2'b01;
            last_grant <= sel;
            tx_start   <= 1'b1;
            busy       <= 1'b1;
          end
        end
        BUSY: begin
          // Dropping the request ends the frame, whether complete or aborted.
          if (!owner_req) begin
            state    <= DONE;
            done     <= grant;
            grant    <= 2'b00;
            tx_start <= 1'b0;
          end
        end
        DONE: begin
          done    <= 2'b00;
          gap_cnt <= gap_cycles;
          if (gap_cycles != '0) begin
            state <= GAP;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - GAP_W'(1);
          if (gap_cnt == GAP_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_goc_tx_sched.sv
// Directed bench for goc_tx_sched: inputs driven 1ns after the rising edge,
// outputs sampled on the falling edge.
module tb_goc_tx_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic        tx_enable;
  logic [21:0] gap_cycles;
  logic        rq0_req, rq0_frame_valid, rq0_next;
  logic [7:0]  rq0_data;
  logic        rq1_req, rq1_frame_valid, rq1_next;
  logic [7:0]  rq1_data;
  logic [7:0]  tx_data;
  logic        tx_empty, tx_re, tx_start, busy;
  logic [1:0]  grant, done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  goc_tx_sched #(.GAP_W(22)) dut (
    .clk(clk), .resetn(resetn), .tx_enable(tx_enable), .gap_cycles(gap_cycles),
    .rq0_req(rq0_req), .rq0_frame_valid(rq0_frame_valid), .rq0_data(rq0_data), .rq0_next(rq0_next),
    .rq1_req(rq1_req), .rq1_frame_valid(rq1_frame_valid), .rq1_data(rq1_data), .rq1_next(rq1_next),
    .tx_data(tx_data), .tx_empty(tx_empty), .tx_re(tx_re), .tx_start(tx_start),
    .grant(grant), .done(done), .busy(busy)
  );

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; tx_enable = 1'b1; gap_cycles = 22'd4;
    rq0_req = 1'b1; rq0_frame_valid = 1'b1; rq0_data = 8'h12;
    rq1_req = 1'b0; rq1_frame_valid = 1'b0; rq1_data = 8'h00; tx_re = 1'b0;
    nxt(); nxt();
    @(negedge clk);
    total_cnt++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant); else pass_cnt++;
    total_cnt++; if (done !== 2'b00) $display("FAIL reset_done: got %b want 00", done); else pass_cnt++;
    total_cnt++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b want 0", tx_start); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (tx_empty !== 1'b1) $display("FAIL reset_tx_empty: got %b want 1", tx_empty); else pass_cnt++;
    total_cnt++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data); else pass_cnt++;
    nxt();
    resetn = 1'b1; rq0_req = 1'b0; rq0_frame_valid = 1'b0;
    nxt();
  endtask

  task automatic test_single_frame();
    logic [7:0] sf_bytes [3] = '{8'hA5, 8'h3C, 8'hFF};
    int nexts;
    int bc;
    gap_cycles = 22'd4;
    rq0_req = 1'b1; rq0_frame_valid = 1'b1; rq0_data = 8'hA5; tx_re = 1'b0;
    @(negedge clk);
    total_cnt++; if (grant !== 2'b00) $display("FAIL sf_pre_grant: got %b want 00", grant); else pass_cnt++;
    nxt();
    @(negedge clk);
    total_cnt++; if (grant !== 2'b01) $display("FAIL sf_grant: got %b want 01", grant); else pass_cnt++;
    total_cnt++; if (tx_start !== 1'b1) $display("FAIL sf_tx_start: got %b want 1", tx_start); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL sf_busy: got %b want 1", busy); else pass_cnt++;
    nxt();
    nexts = 0;
    for (int i = 0; i < 3; i++) begin
      rq0_data = sf_bytes[i]; tx_re = 1'b1;
      @(negedge clk);
      total_cnt++; if (tx_data !== sf_bytes[i]) $display("FAIL sf_tx_data[%0d]: got %h want %h", i, tx_data, sf_bytes[i]); else pass_cnt++;
      if (rq0_next === 1'b1) nexts++;
      nxt();
    end
    rq0_frame_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (tx_empty !== 1'b1) $display("FAIL sf_empty_after: got %b want 1", tx_empty); else pass_cnt++;
    total_cnt++; if (rq0_next !== 1'b0) $display("FAIL sf_next_when_empty: got %b want 0", rq0_next); else pass_cnt++;
    total_cnt++; if (nexts !== 3) $display("FAIL sf_next_count: got %0d want 3", nexts); else pass_cnt++;
    nxt();
    rq0_req = 1'b0; tx_re = 1'b0;
    @(negedge clk);
    total_cnt++; if (grant !== 2'b01) $display("FAIL sf_grant_hold: got %b want 01", grant); else pass_cnt++;
    nxt();
    @(negedge clk);
    total_cnt++; if (done !== 2'b01) $display("FAIL sf_done: got %b want 01", done); else pass_cnt++;
    total_cnt++; if (grant !== 2'b00) $display("FAIL sf_done_grant: got %b want 00", grant); else pass_cnt++;
    total_cnt++; if (tx_start !== 1'b0) $display("FAIL sf_done_tx_start: got %b want 0", tx_start); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL sf_done_busy: got %b want 1", busy); else pass_cnt++;
    bc = 1;
    nxt();
    gap_cycles = 22'd9;
    @(negedge clk);
    total_cnt++; if (done !== 2'b00) $display("FAIL sf_done_width: got %b want 00", done); else pass_cnt++;
    if (busy === 1'b1) bc++;
    while (busy === 1'b1 && bc < 50) begin
      nxt();
      @(negedge clk);
      if (busy === 1'b1) bc++;
    end
    total_cnt++; if (bc !== 5) $display("FAIL sf_busy_tail: got %0d cycles want 5", bc); else pass_cnt++;
    nxt();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    resetn = 1'b0;
    nxt();
    resetn = 1'b1; gap_cycles = 22'd0;
    rq0_req = 1'b1; rq1_req = 1'b1; rq0_frame_valid = 1'b1; rq1_frame_valid = 1'b1;
    rq0_data = 8'h11; rq1_data = 8'h22; tx_re = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      total_cnt++; if (grant !== 2'b00) $display("FAIL rr_idle_grant[%0d]: got %b want 00", k, grant); else pass_cnt++;
      nxt();
      tx_re = 1'b1;
      @(negedge clk);
      total_cnt++; if (grant !== exp) $display("FAIL rr_grant[%0d]: got %b want %b", k, grant, exp); else pass_cnt++;
      total_cnt++; if (tx_data !== (exp[0] ? 8'h11 : 8'h22)) $display("FAIL rr_tx_data[%0d]: got %h want %h", k, tx_data, (exp[0] ? 8'h11 : 8'h22)); else pass_cnt++;
      total_cnt++; if ({rq1_next, rq0_next} !== exp) $display("FAIL rr_next0[%0d]: got %b want %b", k, {rq1_next, rq0_next}, exp); else pass_cnt++;
      nxt();
      @(negedge clk);
      total_cnt++; if ({rq1_next, rq0_next} !== exp) $display("FAIL rr_next1[%0d]: got %b want %b", k, {rq1_next, rq0_next}, exp); else pass_cnt++;
      nxt();
      tx_re = 1'b0;
      if (exp[0]) rq0_req = 1'b0; else rq1_req = 1'b0;
      @(negedge clk);
      total_cnt++; if (grant !== exp) $display("FAIL rr_grant_end[%0d]: got %b want %b", k, grant, exp); else pass_cnt++;
      nxt();
      @(negedge clk);
      total_cnt++; if (done !== exp) $display("FAIL rr_done[%0d]: got %b want %b", k, done, exp); else pass_cnt++;
      nxt();
      rq0_req = 1'b1; rq1_req = 1'b1;
    end
    rq0_req = 1'b0; rq1_req = 1'b0;
    nxt();
  endtask

  task automatic test_gap_zero();
    gap_cycles = 22'd0;
    rq1_req = 1'b1; rq1_frame_valid = 1'b1; rq1_data = 8'h5A; tx_re = 1'b0;
    nxt();
    @(negedge clk);
    total_cnt++; if (grant !== 2'b10) $display("FAIL gz_grant: got %b want 10", grant); else pass_cnt++;
    nxt();
    tx_re = 1'b1;
    @(negedge clk);
    total_cnt++; if (rq1_next !== 1'b1) $display("FAIL gz_next: got %b want 1", rq1_next); else pass_cnt++;
    nxt();
    tx_re = 1'b0; rq1_req = 1'b0;
    nxt();
    @(negedge clk);
    total_cnt++; if (done !== 2'b10) $display("FAIL gz_done: got %b want 10", done); else pass_cnt++;
    rq1_req = 1'b1;
    nxt();
    @(negedge clk);
    total_cnt++; if (grant !== 2'b00) $display("FAIL gz_idle_grant: got %b want 00", grant); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL gz_idle_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 2'b00) $display("FAIL gz_idle_done: got %b want 00", done); else pass_cnt++;
    nxt();
    @(negedge clk);
    total_cnt++; if (grant !== 2'b10) $display("FAIL gz_regrant: got %b want 10", grant); else pass_cnt++;
    total_cnt++; if (tx_start !== 1'b1) $display("FAIL gz_tx_start: got %b want 1", tx_start); else pass_cnt++;
    rq1_req = 1'b0;
    nxt();
    nxt();
  endtask

  task automatic test_empty();
    rq1_req = 1'b1; rq1_frame_valid = 1'b1; rq1_data = 8'h77; tx_re = 1'b0;
    nxt();
    rq1_frame_valid = 1'b0; tx_re = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++; if (tx_empty !== 1'b1) $display("FAIL em_tx_empty[%0d]: got %b want 1", i, tx_empty); else pass_cnt++;
      total_cnt++; if (rq1_next !== 1'b0) $display("FAIL em_next[%0d]: got %b want 0", i, rq1_next); else pass_cnt++;
      nxt();
    end
    rq1_frame_valid = 1'b1; rq1_data = 8'h88;
    @(negedge clk);
    total_cnt++; if (tx_empty !== 1'b0) $display("FAIL em_resume_empty: got %b want 0", tx_empty); else pass_cnt++;
    total_cnt++; if (rq1_next !== 1'b1) $display("FAIL em_resume_next: got %b want 1", rq1_next); else pass_cnt++;
    total_cnt++; if (tx_data !== 8'h88) $display("FAIL em_resume_data: got %h want 88", tx_data); else pass_cnt++;
    nxt();
    tx_re = 1'b0; rq1_req = 1'b0;
    nxt();
    @(negedge clk);
    total_cnt++; if (done !== 2'b10) $display("FAIL em_done: got %b want 10", done); else pass_cnt++;
    nxt();
  endtask

  task automatic test_enable();
    int bad;
    bad = 0;
    tx_enable = 1'b0;
    rq0_req = 1'b1; rq0_frame_valid = 1'b1; rq0_data = 8'h42; tx_re = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant !== 2'b00 || busy !== 1'b0) bad++;
      nxt();
    end
    total_cnt++; if (bad !== 0) $display("FAIL en_blocked: got %0d granted cycles want 0", bad); else pass_cnt++;
    tx_enable = 1'b1;
    nxt();
    @(negedge clk);
    total_cnt++; if (grant !== 2'b01) $display("FAIL en_grant: got %b want 01", grant); else pass_cnt++;
    tx_enable = 1'b0;
    nxt();
    tx_re = 1'b1;
    @(negedge clk);
    total_cnt++; if (rq0_next !== 1'b1) $display("FAIL en_next: got %b want 1", rq0_next); else pass_cnt++;
    total_cnt++; if (tx_start !== 1'b1) $display("FAIL en_tx_start: got %b want 1", tx_start); else pass_cnt++;
    nxt();
    tx_re = 1'b0; rq0_req = 1'b0;
    nxt();
    @(negedge clk);
    total_cnt++; if (done !== 2'b01) $display("FAIL en_done: got %b want 01", done); else pass_cnt++;
    nxt();
    tx_enable = 1'b1;
  endtask

  task automatic test_reset_midframe();
    rq0_req = 1'b1; rq0_frame_valid = 1'b1; rq0_data = 8'h99; tx_re = 1'b0;
    nxt();
    @(negedge clk);
    total_cnt++; if (grant !== 2'b01) $display("FAIL rm_grant: got %b want 01", grant); else pass_cnt++;
    resetn = 1'b0; rq1_req = 1'b1; rq1_frame_valid = 1'b1;
    nxt();
    resetn = 1'b1;
    @(negedge clk);
    total_cnt++; if (grant !== 2'b00) $display("FAIL rm_grant_clr: got %b want 00", grant); else pass_cnt++;
    total_cnt++; if (tx_start !== 1'b0) $display("FAIL rm_tx_start: got %b want 0", tx_start); else pass_cnt++;
    total_cnt++; if (done !== 2'b00) $display("FAIL rm_done: got %b want 00", done); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", busy); else pass_cnt++;
    nxt();
    @(negedge clk);
    total_cnt++; if (grant !== 2'b01) $display("FAIL rm_first_grant: got %b want 01", grant); else pass_cnt++;
    rq0_req = 1'b0; rq1_req = 1'b0;
    nxt();
    nxt();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_gap_zero();
    test_empty();
    test_enable();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
